// File: rtl/stack_register.sv
// -----------------------------------------------------------------------------
// stack_register
//   A LIFO register stack that holds DEPTH words of WIDTH bits. It serves as the
//   MCU return stack and as general push/pop storage on the register-file bus.
//   Writing the register pushes a value and reading it pops one. The current
//   top-of-stack is always driven on data_out.
//
// Ports
//   sysclk     in   1       system clock, rising edge
//   sysreset   in   1       synchronous active-high reset
//   data_out   out  WIDTH   top-of-stack, zero when empty
//   data_in    in   WIDTH   value to push / replace
//   load       in   1       push strobe
//   read       in   1       pop strobe
//   count      out  CW      number of valid entries, CW = $clog2(DEPTH+1)
//   empty      out  1       count == 0
//   full       out  1       count == DEPTH
//   overflow   out  1       sticky: push attempted while full
//   underflow  out  1       sticky: pop attempted while empty
//
// Strobe semantics: load and read are plain per-cycle qualifiers with no
// back-pressure. Each rising edge that samples a strobe high performs exactly
// one operation. Results appear in the following cycle.
//   load only    -> push (dropped and overflow set when full)
//   read only    -> pop  (ignored and underflow set when empty)
//   load + read  -> replace top (acts as a push when empty)
// -----------------------------------------------------------------------------
module stack_register #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                       sysclk,
  input  logic                       sysreset,
  output logic [WIDTH-1:0]           data_out,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       load,
  input  logic                       read,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;

  // Slot addressing. count_q never exceeds DEPTH. When it equals DEPTH, the
  // truncated push address is unused because a push into a full stack is
  // blocked.
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;

  logic is_empty;
  logic is_full;
  logic do_push;
  logic do_pop;
  logic do_replace;
  logic set_overflow;
  logic set_underflow;

  always_comb begin
    push_idx = count_q[AW-1:0];
    top_idx  = count_q[AW-1:0] - AW'(1);
    is_empty = (count_q == '0);
    is_full  = (count_q == CW'(DEPTH));

    // A load with read on an empty stack is a push. DEPTH >= 2, so an empty
    // stack is never full and that push is always allowed.
    do_push       = load && (!read || is_empty) && !is_full;
    do_pop        = read && !load && !is_empty;
    do_replace    = load && read && !is_empty;
    set_overflow  = load && !read && is_full;
    set_underflow = read && !load && is_empty;
  end

  // Pointer and sticky flags.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_push)
        count_q <= count_q + CW'(1);
      else if (do_pop)
        count_q <= count_q - CW'(1);
      if (set_overflow)
        overflow_q <= 1'b1;
      if (set_underflow)
        underflow_q <= 1'b1;
    end
  end

  // Storage has no reset. Slots at or above count_q are never shown. Writes are
  // gated by sysreset so that reset takes priority over a concurrent load.
  always_ff @(posedge sysclk) begin
    if (!sysreset) begin
      if (do_push)
        mem[push_idx] <= data_in;
      else if (do_replace)
        mem[top_idx] <= data_in;
    end
  end

  // data_out depends only on registered state.
  always_comb begin
    data_out  = is_empty ? '0 : mem[top_idx];
    count     = count_q;
    empty     = is_empty;
    full      = is_full;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_stack_register.sv
// -----------------------------------------------------------------------------
// tb_stack_register
//   Directed bench for stack_register at its default size (32 x 16). A LIFO
//   expected queue holds the values that should remain stacked. Immediate
//   assertions compare each observation.
// -----------------------------------------------------------------------------
module tb_stack_register;

  localparam int WIDTH = 16;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             sysclk;
  logic             sysreset;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             read;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  int vectors;
  int miscompares;

  logic [WIDTH-1:0] exp_q[$];

  stack_register #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .sysclk    (sysclk),
    .sysreset  (sysreset),
    .data_out  (data_out),
    .data_in   (data_in),
    .load      (load),
    .read      (read),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- clock ----------------
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] exp_data,
                         input int exp_count, input logic exp_ovf, input logic exp_unf);
    chk({tag, ".data_out"},  32'(data_out),  32'(exp_data));
    chk({tag, ".count"},     32'(count),     32'(exp_count));
    chk({tag, ".empty"},     32'(empty),     32'(exp_count == 0));
    chk({tag, ".full"},      32'(full),      32'(exp_count == DEPTH));
    chk({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  // Top of the expected stack, or zero when it is empty.
  function automatic logic [15:0] exp_top();
    return (exp_q.size() == 0) ? 16'h0000 : exp_q[exp_q.size()-1];
  endfunction

  // ---------------- drivers ----------------
  // Entered and left 1 time unit after a rising edge.
  task automatic cycle(input logic ld, input logic rd, input logic [15:0] d);
    load    = ld;
    read    = rd;
    data_in = d;
    @(posedge sysclk);
    #1;
    load    = 1'b0;
    read    = 1'b0;
    data_in = '0;
  endtask

  task automatic push(input logic [15:0] d);
    cycle(1'b1, 1'b0, d);
    exp_q.push_back(d);
  endtask

  task automatic pop();
    cycle(1'b0, 1'b1, 16'h0000);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
  endtask

  task automatic reset_pulse();
    sysreset = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000);
    sysreset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    sysreset    = 1'b1;
    load        = 1'b0;
    read        = 1'b0;
    data_in     = '0;
    @(posedge sysclk);
    #1;
    @(posedge sysclk);
    #1;
    sysreset = 1'b0;

    // Reset, then idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk_all("idle", 16'h0000, 0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 16'h0000);
    end

    // Three pushes, then three pops.
    push(16'h1111);
    chk("push1.data_out", 32'(data_out), 32'h1111);
    push(16'h2222);
    push(16'h3333);
    chk_all("push3", 16'h3333, 3, 1'b0, 1'b0);
    chk("pop_cycle.data_out", 32'(data_out), 32'h3333);
    pop();
    chk("pop1.data_out", 32'(data_out), 32'h2222);
    pop();
    chk("pop2.data_out", 32'(data_out), 32'h1111);
    pop();
    chk_all("pop3", 16'h0000, 0, 1'b0, 1'b0);

    // Fill to DEPTH, then push into a full stack.
    for (int i = 0; i < DEPTH; i++) begin
      push(16'(i * 16'h0101));
      if (i == DEPTH - 2) chk("almost_full.full", 32'(full), 32'h0);
    end
    chk_all("filled", 16'h1F1F, DEPTH, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'hDEAD);
    chk_all("push_full", 16'h1F1F, DEPTH, 1'b1, 1'b0);

    // Drain in LIFO order. The expected top comes from the model queue.
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      chk($sformatf("drain%0d.data_out", i), 32'(data_out), 32'(exp_top()));
      chk($sformatf("drain%0d.count", i), 32'(count), 32'(DEPTH - 1 - i));
    end
    chk_all("drained", 16'h0000, 0, 1'b1, 1'b0);

    // Pop on empty sets a sticky underflow flag.
    pop();
    chk_all("pop_empty", 16'h0000, 0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 16'h0000);
    chk_all("sticky", 16'h0000, 0, 1'b1, 1'b1);
    reset_pulse();
    chk_all("flags_cleared", 16'h0000, 0, 1'b0, 1'b0);

    // Replace the top of a two-entry stack.
    push(16'hAAAA);
    push(16'hBBBB);
    cycle(1'b1, 1'b1, 16'hCCCC);
    chk_all("replace", 16'hCCCC, 2, 1'b0, 1'b0);
    pop();
    chk_all("replace_pop", 16'hAAAA, 1, 1'b0, 1'b0);
    pop();
    chk_all("replace_drain", 16'h0000, 0, 1'b0, 1'b0);

    // Load with read on an empty stack behaves as a push.
    cycle(1'b1, 1'b1, 16'h1234);
    chk_all("replace_empty", 16'h1234, 1, 1'b0, 1'b0);
    pop();
    chk_all("replace_empty_pop", 16'h0000, 0, 1'b0, 1'b0);

    // Alternate push and pop with no idle cycles between them.
    push(16'h0A0A);
    push(16'h0B0B);
    pop();
    chk("alt.data_out", 32'(data_out), 32'h0A0A);
    push(16'h0C0C);
    chk_all("alt_push", 16'h0C0C, 2, 1'b0, 1'b0);

    // Reset mid-operation takes priority over a concurrent load.
    reset_pulse();
    for (int i = 1; i <= 5; i++) push(16'(i * 16'h1000 + i));
    chk_all("five", 16'h5005, 5, 1'b0, 1'b0);
    sysreset = 1'b1;
    cycle(1'b1, 1'b0, 16'h5555);
    sysreset = 1'b0;
    exp_q.delete();
    chk_all("reset_load", 16'h0000, 0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0000);
    chk_all("after_reset", 16'h0000, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_register.md
# stack_register

Parameterized LIFO register stack (default 32 × 16 bits) used as the MCU return stack and for general push/pop storage. It sits on the MCU register-file bus. Writing the register pushes a value, reading it pops one, and the current top-of-stack is always visible on the register output. Status outputs report occupancy and sticky overflow/underflow errors for debug.

## Interface
Parameters:
- WIDTH, 16, data width in bits.
- DEPTH, 32, maximum number of entries; must be ≥ 2.

Ports, in positional order (the first six are fixed for positional instantiation):
- sysclk  input  1  system clock; all state changes on its rising edge.
- sysreset  input  1  synchronous, active-high reset; one clock, synchronous reset, active high.
- data_out  output  WIDTH  current top-of-stack; all zeros when empty.
- data_in  input  WIDTH  value to push.
- load  input  1  push strobe (register-load qualifier from the bus).
- read  input  1  pop strobe (register-read qualifier from the bus).
- count  output  $clog2(DEPTH+1)  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: a push was attempted while full.
- underflow  output  1  sticky flag: a pop was attempted while empty.

## Operation
- The storage is DEPTH words plus a stack pointer. data_out is derived from registered state only: the top register or the indexed entry, with no combinational path from load, read or data_in.
- Push (load=1, read=0, not full):
  - data_in becomes the new top.
  - The previous top stays reachable underneath it.
  - count increments by 1.
- Pop (read=1, load=0, not empty):
  - The top is discarded and the next-older entry becomes the top.
  - count decrements by 1.
  - The value on data_out during the read cycle is the value the bus consumes.
- Simultaneous load and read (replace):
  - If not empty: the top is overwritten with data_in and count is unchanged.
  - If empty: it behaves as a push and underflow is not set.
- Push while full (load only):
  - Contents and count are unchanged and data_in is dropped.
  - overflow is set to 1.
- Pop while empty (read only): no state change, underflow is set to 1, data_out stays 0.
- Sticky flags are cleared only by sysreset.
- Entries below the top keep strict LIFO order.
- Contents of slots beyond count are don't-care and never appear on data_out.

## Timing
- Reset: when sysreset=1 at a rising edge:
  - count, overflow and underflow go to 0; empty=1, full=0, data_out=0.
  - Reset takes priority over simultaneous load and read.
- Latency: a push, pop or replace issued in cycle N is reflected on data_out, count, empty and full after the rising edge ending cycle N, i.e. visible in cycle N+1.
- Throughput: one operation per cycle. Back-to-back pushes, pops or alternations need no idle cycles.
- load and read are sampled only at the rising edge. Holding a strobe for k cycles performs k operations.
- Flags update on the same edge as the offending operation and are visible in cycle N+1.
- Boundaries:
  - count saturates at DEPTH (full asserted) and at 0 (empty asserted). It never wraps.
  - Pushing into slot DEPTH-1 asserts full on the next cycle.
  - Popping the last entry asserts empty and sets data_out=0 on the next cycle.

## Test plan
- Reset then idle: data_out=0, count=0, empty=1, full=0, overflow=0, underflow=0 for 10 cycles.
- Push 0x1111, 0x2222, 0x3333 on consecutive cycles, then pop three times on consecutive cycles:
  - After the pushes, data_out=0x3333 and count=3.
  - Successive data_out values are 0x3333, 0x2222, 0x1111, then 0x0000.
  - empty=1 at the end and underflow=0.
- Push DEPTH=32 values i*0x0101, then push 0xDEAD:
  - full=1, count=32, overflow=1, data_out=0x1F1F.
  - Popping 32 times returns 0x1F1F down to 0x0000 in order.
- Pop on empty: underflow=1, count stays 0, data_out=0; underflow is still 1 after 5 idle cycles and clears only after a sysreset pulse.
- Replace: with 0xAAAA, 0xBBBB pushed, assert load+read with data_in=0xCCCC:
  - count stays 2 and data_out=0xCCCC.
  - One pop yields data_out=0xAAAA.
- Reset mid-operation: push 5 values, assert sysreset together with load=1 → next cycle count=0, empty=1, data_out=0, and the push is not performed.
